// File: rtl/cpu_common.sv
// Shared CPU-wide types and constants: memory geometry and the response-owner tag
// used to route read data back to the unit that issued the access.
package cpu_common;

  localparam int MEM_ADDR_W = 13;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_BE_W   = MEM_DATA_W / 8;

  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_FETCH = 2'd1,
    OWNER_LS    = 2'd2
  } mem_owner_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment and the
// value sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_async,
  input  logic              clear_i,
  input  logic              inc_i,
  output logic [DATA_W-1:0] count_o
);

  logic [DATA_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {DATA_W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Fetch vs load/store arbiter for the single-port program/data memory, with a
// one-cycle read-response router. Stall counters built only with MEM_ARBITER_PERF_COUNTERS_EN.
module mem_arbiter
  import cpu_common::*;
(
  input  logic                  clk,
  input  logic                  rst_async,
  input  logic                  fetch_req,
  input  logic                  fetch_lock,
  input  logic [MEM_ADDR_W-1:0] fetch_addr,
  output logic                  fetch_gnt,
  output logic                  fetch_rvalid,
  output logic [MEM_DATA_W-1:0] fetch_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [MEM_BE_W-1:0]   ls_be,
  input  logic [MEM_ADDR_W-1:0] ls_addr,
  input  logic [MEM_DATA_W-1:0] ls_wdata,
  output logic                  ls_gnt,
  output logic                  ls_rvalid,
  output logic [MEM_DATA_W-1:0] ls_rdata,
  output logic [MEM_ADDR_W-1:0] mem_addr,
  output logic                  mem_we,
  output logic [MEM_BE_W-1:0]   mem_be,
  output logic [MEM_DATA_W-1:0] mem_wdata,
  input  logic [MEM_DATA_W-1:0] mem_rdata,
  input  logic                  perf_clear,
  output logic [15:0]           fetch_stall_cnt,
  output logic [15:0]           ls_stall_cnt
);

  mem_owner_t last_gnt_q, last_gnt_d;
  mem_owner_t rsp_owner_q, rsp_owner_d;
  logic       lock_pending_q, lock_pending_d;
  logic       fetch_win, ls_win;

  // Grants are suppressed while reset is asserted so every output reads 0 in reset.
  always_comb begin
    fetch_win = ~rst_async & fetch_req &
                (lock_pending_q | ~ls_req | (last_gnt_q == OWNER_LS));
    ls_win    = ~rst_async & ls_req & ~fetch_win;

    // Only the first locked grant arms the lock, capping a locked burst at two words.
    lock_pending_d = fetch_win & fetch_lock & ~lock_pending_q;

    last_gnt_d = last_gnt_q;
    if (fetch_win) begin
      last_gnt_d = OWNER_FETCH;
    end else if (ls_win) begin
      last_gnt_d = OWNER_LS;
    end

    rsp_owner_d = OWNER_NONE;
    if (fetch_win) begin
      rsp_owner_d = OWNER_FETCH;
    end else if (ls_win && !ls_we) begin
      rsp_owner_d = OWNER_LS;
    end
  end

  always_ff @(posedge clk or posedge rst_async) begin
    if (rst_async) begin
      last_gnt_q     <= OWNER_LS;
      lock_pending_q <= 1'b0;
      rsp_owner_q    <= OWNER_NONE;
    end else begin
      last_gnt_q     <= last_gnt_d;
      lock_pending_q <= lock_pending_d;
      rsp_owner_q    <= rsp_owner_d;
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_wdata = '0;
    if (fetch_win) begin
      mem_addr = fetch_addr;
    end else if (ls_win) begin
      mem_addr = ls_addr;
      if (ls_we) begin
        mem_we    = 1'b1;
        mem_be    = ls_be;
        mem_wdata = ls_wdata;
      end
    end
  end

  assign fetch_gnt    = fetch_win;
  assign ls_gnt       = ls_win;
  assign fetch_rvalid = (rsp_owner_q == OWNER_FETCH);
  assign ls_rvalid    = (rsp_owner_q == OWNER_LS);
  assign fetch_rdata  = fetch_rvalid ? mem_rdata : '0;
  assign ls_rdata     = ls_rvalid ? mem_rdata : '0;

`ifdef MEM_ARBITER_PERF_COUNTERS_EN
  sat_counter #(.DATA_W(16)) u_fetch_cnt (
    .clk       (clk),
    .rst_async (rst_async),
    .clear_i   (perf_clear),
    .inc_i     (fetch_req & ~fetch_win),
    .count_o   (fetch_stall_cnt)
  );

  sat_counter #(.DATA_W(16)) u_ls_cnt (
    .clk       (clk),
    .rst_async (rst_async),
    .clear_i   (perf_clear),
    .inc_i     (ls_req & ~ls_win),
    .count_o   (ls_stall_cnt)
  );
`else
  logic unused_perf_clear;
  assign unused_perf_clear = perf_clear;
  assign fetch_stall_cnt   = '0;
  assign ls_stall_cnt      = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised and directed bench for mem_arbiter against a rule-level arbitration model
// and a behavioural memory; covers MEM_ARBITER_PERF_COUNTERS_EN builds as well.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_async;
  logic        fetch_req, fetch_lock;
  logic [12:0] fetch_addr;
  logic        fetch_gnt, fetch_rvalid;
  logic [15:0] fetch_rdata;
  logic        ls_req, ls_we;
  logic [1:0]  ls_be;
  logic [12:0] ls_addr;
  logic [15:0] ls_wdata;
  logic        ls_gnt, ls_rvalid;
  logic [15:0] ls_rdata;
  logic [12:0] mem_addr;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        perf_clear;
  logic [15:0] fetch_stall_cnt, ls_stall_cnt;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst_async(rst_async),
    .fetch_req(fetch_req), .fetch_lock(fetch_lock), .fetch_addr(fetch_addr),
    .fetch_gnt(fetch_gnt), .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_be(ls_be), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .perf_clear(perf_clear),
    .fetch_stall_cnt(fetch_stall_cnt), .ls_stall_cnt(ls_stall_cnt)
  );

  // Behavioural single-port synchronous memory: write at the edge, read data next cycle.
  logic [15:0] mem [0:8191];
  always @(posedge clk) begin
    if (mem_we) begin
      if (mem_be[0]) mem[mem_addr][7:0]  <= mem_wdata[7:0];
      if (mem_be[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
    end
    mem_rdata <= mem[mem_addr];
  end

  int total = 0;
  int bad   = 0;

  // Reference model state: who won the last contention, lock armed, stall counts.
  bit m_last_fetch;
  bit m_lock;
  int m_fcnt, m_lcnt;
  int g_win;  // 0 none, 1 fetch, 2 ls for the most recent cycle

  logic [33:0] got_grant, exp_grant;
  logic [33:0] got_rsp, exp_rsp;
  logic [31:0] got_cnt, exp_cnt;

  function automatic logic [33:0] all_outputs();
    return {fetch_gnt, ls_gnt, fetch_rvalid, ls_rvalid, mem_addr, mem_we, mem_be,
            mem_wdata[7:0] | fetch_rdata[7:0] | ls_rdata[7:0] | fetch_stall_cnt[7:0] | ls_stall_cnt[7:0],
            |{mem_wdata[15:8], fetch_rdata[15:8], ls_rdata[15:8], fetch_stall_cnt[15:8], ls_stall_cnt[15:8]}};
  endfunction

  task automatic idle_inputs();
    fetch_req = 0; fetch_lock = 0; fetch_addr = '0;
    ls_req = 0; ls_we = 0; ls_be = '0; ls_addr = '0; ls_wdata = '0;
    perf_clear = 0;
  endtask

  task automatic model_reset();
    m_last_fetch = 0; m_lock = 0; m_fcnt = 0; m_lcnt = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_async = 1;
    @(posedge clk); #1;
    rst_async = 0;
    model_reset();
  endtask

  // One clock with the currently driven inputs: predict from the arbitration rules,
  // capture actual grant (mid-cycle) and response/counters (after the edge).
  task automatic run_cycle();
    int win, rsp;
    logic [12:0] e_addr;
    logic        e_we;
    logic [15:0] e_data;
    #2;
    if (fetch_req && ls_req) win = (m_lock || !m_last_fetch) ? 1 : 2;
    else if (fetch_req)      win = 1;
    else if (ls_req)         win = 2;
    else                     win = 0;
    e_addr = (win == 1) ? fetch_addr : (win == 2) ? ls_addr : 13'd0;
    e_we   = (win == 2) && ls_we;
    exp_grant = {win == 1, win == 2, e_addr, e_we, e_we ? ls_be : 2'b00, e_we ? ls_wdata : 16'h0};
    got_grant = {fetch_gnt, ls_gnt, mem_addr, mem_we, mem_be, mem_wdata};
    rsp    = (win == 1) ? 1 : (win == 2 && !ls_we) ? 2 : 0;
    e_data = mem[e_addr];
    g_win  = win;
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    if (perf_clear) begin
      m_fcnt = 0; m_lcnt = 0;
    end else begin
      if (fetch_req && win != 1 && m_fcnt < 65535) m_fcnt++;
      if (ls_req && win != 2 && m_lcnt < 65535) m_lcnt++;
    end
`endif
    m_lock = (win == 1) && fetch_lock && !m_lock;
    if (win != 0) m_last_fetch = (win == 1);
    @(posedge clk); #1;
    exp_rsp = {rsp == 1, (rsp == 1) ? e_data : 16'h0, rsp == 2, (rsp == 2) ? e_data : 16'h0};
    got_rsp = {fetch_rvalid, fetch_rdata, ls_rvalid, ls_rdata};
    exp_cnt = {m_fcnt[15:0], m_lcnt[15:0]};
    got_cnt = {fetch_stall_cnt, ls_stall_cnt};
  endtask

  task automatic ls_write(input logic [12:0] a, input logic [1:0] be, input logic [15:0] d);
    idle_inputs();
    ls_req = 1; ls_we = 1; ls_addr = a; ls_be = be; ls_wdata = d;
    run_cycle();
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    fetch_req = 1; ls_req = 1; ls_we = 1; ls_be = 2'b11; ls_addr = 13'h1234; ls_wdata = 16'hFFFF;
    fetch_addr = 13'h0ABC;
    rst_async = 1;
    #3;
    total++;
    if (all_outputs() !== 34'h0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0", all_outputs());
    end
    @(posedge clk); #1;
    rst_async = 0;
    idle_inputs();
    model_reset();
  endtask

  task automatic test_fetch_only();
    ls_write(13'h0005, 2'b11, 16'h1234);
    apply_reset();
    fetch_req = 1; fetch_addr = 13'h0005;
    run_cycle();
    total++;
    if (got_grant !== {1'b1, 1'b0, 13'h0005, 1'b0, 2'b00, 16'h0}) begin
      bad++; $display("FAIL fetch_only_grant got=%h exp=%h", got_grant, {2'b10, 13'h0005, 19'h0});
    end
    fetch_req = 0;
    total++;
    if (got_rsp !== {1'b1, 16'h1234, 1'b0, 16'h0}) begin
      bad++; $display("FAIL fetch_only_rsp got=%h exp=%h", got_rsp, {1'b1, 16'h1234, 17'h0});
    end
  endtask

  task automatic test_alternate();
    ls_write(13'h0010, 2'b11, 16'hA010);
    ls_write(13'h0020, 2'b11, 16'hB020);
    apply_reset();
    fetch_req = 1; fetch_addr = 13'h0010;
    ls_req = 1; ls_addr = 13'h0020;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      total++;
      if (got_grant[33:32] !== ((i % 2 == 0) ? 2'b10 : 2'b01) || got_grant !== exp_grant) begin
        bad++; $display("FAIL alternate_grant[%0d] got=%h exp=%h", i, got_grant, exp_grant);
      end
      total++;
      if (got_rsp !== ((i % 2 == 0) ? {1'b1, 16'hA010, 17'h0} : {17'h0, 1'b1, 16'hB020})) begin
        bad++; $display("FAIL alternate_rsp[%0d] got=%h exp=%h", i, got_rsp, exp_rsp);
      end
    end
    idle_inputs();
  endtask

  task automatic test_write();
    ls_write(13'h1FFF, 2'b11, 16'h5555);
    ls_write(13'h1FFF, 2'b10, 16'hABCD);
    total++;
    if (got_grant !== {1'b0, 1'b1, 13'h1FFF, 1'b1, 2'b10, 16'hABCD}) begin
      bad++; $display("FAIL write_grant got=%h exp=%h", got_grant, {2'b01, 13'h1FFF, 1'b1, 2'b10, 16'hABCD});
    end
    total++;
    if (got_rsp !== 34'h0) begin
      bad++; $display("FAIL write_no_rvalid got=%h exp=0", got_rsp);
    end
    total++;
    if (mem[13'h1FFF] !== 16'hAB55) begin
      bad++; $display("FAIL write_bytes got=%h exp=ab55", mem[13'h1FFF]);
    end
    ls_req = 1; ls_addr = 13'h1FFF;
    run_cycle();
    idle_inputs();
    total++;
    if (got_rsp !== {17'h0, 1'b1, 16'hAB55}) begin
      bad++; $display("FAIL write_readback got=%h exp=%h", got_rsp, {17'h0, 1'b1, 16'hAB55});
    end
  endtask

  task automatic test_lock();
    logic [1:0] want [4];
    want[0] = 2'b10; want[1] = 2'b10; want[2] = 2'b01; want[3] = 2'b10;
    apply_reset();
    fetch_req = 1; fetch_lock = 1; fetch_addr = 13'h0040;
    ls_req = 1; ls_addr = 13'h0041;
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      total++;
      if (got_grant[33:32] !== want[i] || got_grant !== exp_grant) begin
        bad++; $display("FAIL lock_grant[%0d] got=%h exp=%h", i, got_grant, exp_grant);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    fetch_req = 1; fetch_addr = 13'h0010;
    run_cycle();
    total++;
    if (got_rsp[33] !== 1'b1) begin
      bad++; $display("FAIL midrst_pre_rvalid got=%b exp=1", got_rsp[33]);
    end
    ls_req = 1; ls_addr = 13'h0020;
    #1 rst_async = 1;
    #1;
    total++;
    if (all_outputs() !== 34'h0) begin
      bad++; $display("FAIL midrst_outputs got=%h exp=0", all_outputs());
    end
    @(posedge clk); #1;
    rst_async = 0;
    model_reset();
    run_cycle();
    total++;
    if (got_grant[33:32] !== 2'b10) begin
      bad++; $display("FAIL midrst_first_contention got=%b exp=10", got_grant[33:32]);
    end
    idle_inputs();
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      if (!(fetch_req && g_win != 1)) begin
        fetch_req  = ($urandom_range(0, 1) == 1);
        fetch_addr = 13'($urandom_range(0, 15));
      end
      fetch_lock = ($urandom_range(0, 3) == 0);
      if (!(ls_req && g_win != 2)) begin
        ls_req   = ($urandom_range(0, 1) == 1);
        ls_we    = ($urandom_range(0, 2) == 0);
        ls_be    = 2'($urandom_range(0, 3));
        ls_addr  = 13'($urandom_range(0, 15));
        ls_wdata = 16'($urandom);
      end
      perf_clear = ($urandom_range(0, 31) == 0);
      run_cycle();
      total++;
      if (got_grant !== exp_grant) begin
        bad++; $display("FAIL rand_grant[%0d] got=%h exp=%h", i, got_grant, exp_grant);
      end
      total++;
      if (got_rsp !== exp_rsp) begin
        bad++; $display("FAIL rand_rsp[%0d] got=%h exp=%h", i, got_rsp, exp_rsp);
      end
      total++;
      if (got_cnt !== exp_cnt) begin
        bad++; $display("FAIL rand_cnt[%0d] got=%h exp=%h", i, got_cnt, exp_cnt);
      end
    end
    idle_inputs();
  endtask

  task automatic test_perf();
    apply_reset();
    fetch_req = 1; fetch_lock = 1; fetch_addr = 13'h0003;
    ls_req = 1; ls_addr = 13'h0004;
    run_cycle();
    run_cycle();
    total++;
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    if (ls_stall_cnt !== 16'd2) begin
      bad++; $display("FAIL perf_ls_stall got=%0d exp=2", ls_stall_cnt);
    end
`else
    if (got_cnt !== 32'h0) begin
      bad++; $display("FAIL perf_disabled got=%h exp=0", got_cnt);
    end
`endif
    idle_inputs();
    perf_clear = 1;
    run_cycle();
    perf_clear = 0;
    total++;
    if (got_cnt !== 32'h0) begin
      bad++; $display("FAIL perf_clear got=%h exp=0", got_cnt);
    end
`ifdef MEM_ARBITER_PERF_COUNTERS_EN
    force dut.u_ls_cnt.count_q = 16'hFFFE;
    #1 release dut.u_ls_cnt.count_q;
    m_lcnt = 16'hFFFE;
    apply_reset_free_lock();
    fetch_req = 1; fetch_lock = 1; fetch_addr = 13'h0003;
    ls_req = 1; ls_addr = 13'h0004;
    for (int i = 0; i < 5; i++) run_cycle();
    total++;
    if (ls_stall_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL perf_saturate got=%h exp=ffff", ls_stall_cnt);
    end
`endif
    idle_inputs();
  endtask

  // Leaves counters intact; just makes the model agree that no lock is armed.
  task automatic apply_reset_free_lock();
    idle_inputs();
    run_cycle();
  endtask

  initial begin
    rst_async = 1;
    idle_inputs();
    model_reset();
    g_win = 0;
    test_reset();
    test_fetch_only();
    test_alternate();
    test_write();
    test_lock();
    test_reset_mid();
    test_random();
    test_perf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter for the CPU's single-port 8K×16 synchronous program/data memory. It shares the memory between the fetch unit (read-only, may need two consecutive words for a misaligned 2-byte instruction) and the load/store path (reads and byte-enabled writes). It grants one access per cycle and routes each read response back to its owner. It sits between the CPU core and the memory macro.

## Interface
- No parameters; widths are fixed by package constants (13-bit word address, 16-bit data).
- Clocking and reset (already decided): reset `rst_async`, asynchronous, active-high; clock `clk`.
- clk  in  1  system clock
- rst_async  in  1  asynchronous active-high reset
- fetch_req  in  1  fetch read request; hold until granted
- fetch_lock  in  1  request the next cycle's grant as well (second word of a misaligned fetch)
- fetch_addr  in  13  fetch word address; stable while fetch_req=1 and not granted
- fetch_gnt  out  1  fetch accepted this cycle
- fetch_rvalid  out  1  fetch read data valid
- fetch_rdata  out  16  fetch read data; 0 when fetch_rvalid=0
- ls_req  in  1  load/store request; hold until granted
- ls_we  in  1  1 = write, 0 = read
- ls_be  in  2  byte enables for a write ([1] = bits 15:8)
- ls_addr  in  13  load/store word address
- ls_wdata  in  16  write data
- ls_gnt  out  1  load/store accepted this cycle
- ls_rvalid  out  1  load read data valid (never asserted for writes)
- ls_rdata  out  16  load data; 0 when ls_rvalid=0
- mem_addr  out  13  memory address; 0 when no grant
- mem_we  out  1  memory write strobe
- mem_be  out  2  memory byte enables; 0 unless mem_we=1
- mem_wdata  out  16  memory write data; 0 unless mem_we=1
- mem_rdata  in  16  memory read data, valid the cycle after its address
- perf_clear  in  1  synchronous clear of stall counters
- fetch_stall_cnt  out  16  cycles with fetch_req=1 and fetch_gnt=0
- ls_stall_cnt  out  16  cycles with ls_req=1 and ls_gnt=0

## Operation
- Grant is combinational: the winner's address, write strobe and data drive `mem_*` in the same cycle. At most one grant per cycle.
- Winner selection, in priority order:
  1. If `lock_pending`=1 and fetch_req=1, fetch wins.
  2. Otherwise, with a single requester, that requester wins.
  3. Otherwise, with both requesting, round-robin: the requester not recorded in `last_gnt` wins.
- `last_gnt` (FETCH/LS) is updated on every grant. Reset value is LS, so fetch wins the first contention.
- Lock rule:
  - `lock_pending` is set when fetch is granted with fetch_lock=1 and `lock_pending`=0.
  - It is cleared on any other cycle.
  - The result is at most two consecutive locked fetch grants. A lock request during the second grant is ignored, which guarantees load/store progress.
- Response routing:
  - `rsp_owner` (NONE/FETCH/LS) registers the owner of a granted read: FETCH, or LS with ls_we=0.
  - `rsp_owner` is NONE for a granted write or when there is no grant.
  - The next cycle, the matching rvalid is 1 and its rdata equals mem_rdata.
- Writes commit at the granting clock edge. A read of the same address on the next cycle returns the new data; that is the memory's behaviour, not a bypass.
- Reset value of every output: 0. Internal state on reset: `last_gnt`=LS, `lock_pending`=0, `rsp_owner`=NONE, counters=0.
- Reset mid-operation: an outstanding response is dropped, and rvalid goes to 0 asynchronously.

## Timing
- Cycle N: req=1 with grant → gnt=1 and mem_addr=addr in N.
- Cycle N+1: rvalid=1. Read latency is 1 cycle from grant, so back-to-back grants give one response per cycle, in order.
- A requester not granted in N must keep req, addr and data stable into N+1; it has no combinational path from gnt to req.
- A requester may drop req in the cycle after its gnt, or keep it high for a new access.

## Configuration
- Macro: `MEM_ARBITER_PERF_COUNTERS_EN`.
- When defined:
  - fetch_stall_cnt and ls_stall_cnt increment each stall cycle and saturate at 0xFFFF.
  - perf_clear=1 loads 0; it takes priority over increment.
- When undefined: both counter outputs are tied to 0, perf_clear is ignored, and no counter flops are built. Ports exist in both builds.

## Structure
- `cpu_common` gains:
  - `mem_owner_t` enum {OWNER_NONE, OWNER_FETCH, OWNER_LS}
  - `MEM_ADDR_W`=13 and `MEM_DATA_W`=16 constants
- Sub-module `sat_counter`: 16-bit saturating counter with inc/clear. Instantiated twice, only under the macro.

## Test plan
- Fetch only, with mem_rdata model M[0x0005]=0x1234. After reset, fetch_req with addr 0x0005 → fetch_gnt=1 and mem_addr=0x0005 in the same cycle; next cycle fetch_rvalid=1 and fetch_rdata=0x1234, ls_rvalid=0.
- Both requesters read 0x0010/0x0020 continuously from reset → grants alternate fetch, ls, fetch, ls; rvalids alternate one cycle later with the correct data routed.
- LS write, addr 0x1FFF, be=2'b10, wdata 0xABCD → mem_we=1, mem_be=2'b10, mem_wdata=0xABCD for one cycle; no ls_rvalid next cycle; M[0x1FFF][15:8]=0xAB.
- Both requesting, fetch_lock=1 throughout → fetch granted in cycles 0 and 1, ls granted in cycle 2, fetch granted in cycle 3 (new lock).
- rst_async pulsed in the cycle after a fetch grant → fetch_rvalid=0 immediately and all outputs 0. First contention after release goes to fetch.
- With the macro defined:
  - ls_req held during a 2-cycle fetch lock → ls_stall_cnt=2.
  - perf_clear → 0.
  - Counter forced to 0xFFFE plus 3 stall cycles → 0xFFFF.
  - Without the macro, both counters read 0.
